plic: RTL and testbench

- Platform-level external interrupt controller for the single-hart core; sits beside the machine timer on the same peripheral bus.
- Gathers level-sensitive device interrupt lines and applies per-source priority and enable.
- Presents one registered external-interrupt line to the core CSR unit, alongside the timer interrupt line.
- Software services interrupts through a claim/complete register using the standard valid/addr/wdata/wstrb/rdata/ready peripheral handshake.

---
 rtl/plic_if.sv | 23 ++
 rtl/plic.sv | 159 +++++++++++++++
 tb/tb_plic.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/plic_if.sv
// Peripheral bus bundle for the PLIC: valid/addr/wdata/wstrb request with a
// one-cycle registered rdata/ready response.
//   master: drives plic_valid, plic_instr, plic_addr, plic_wdata, plic_wstrb
//   slave : drives plic_rdata, plic_ready
interface plic_if;
  logic        plic_valid;
  logic        plic_instr;
  logic [31:0] plic_addr;
  logic [31:0] plic_wdata;
  logic [3:0]  plic_wstrb;
  logic [31:0] plic_rdata;
  logic        plic_ready;

  modport master (
    output plic_valid, plic_instr, plic_addr, plic_wdata, plic_wstrb,
    input  plic_rdata, plic_ready
  );

  modport slave (
    input  plic_valid, plic_instr, plic_addr, plic_wdata, plic_wstrb,
    output plic_rdata, plic_ready
  );
endinterface

// File: rtl/plic.sv
// Platform-level external interrupt controller for a single hart.
// Level-sensitive sources pass through a per-source gateway (idle / pending /
// in-service), are arbitrated by priority against a threshold, and raise one
// registered external interrupt. Software claims/completes via offset 3.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - peripheral bus slave (plic_if.slave)
//   irq_src   - level interrupt requests, synchronous to clk
//   ext_irpt  - registered external interrupt request to the core
module plic #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  plic_if.slave              bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               ext_irpt
);

  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] OFF_PENDING   = 4'd0;
  localparam logic [3:0] OFF_ENABLE    = 4'd1;
  localparam logic [3:0] OFF_THRESHOLD = 4'd2;
  localparam logic [3:0] OFF_CLAIM     = 4'd3;
  localparam int unsigned OFF_PRIO_BASE = 4;

  // Registered state
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] enable;
  logic [PRIO_W-1:0]  threshold;
  logic [PRIO_W-1:0]  prio [NUM_SRC];

  // Next-state values
  logic [NUM_SRC-1:0] pending_n;
  logic [NUM_SRC-1:0] in_service_n;
  logic [NUM_SRC-1:0] enable_n;
  logic [PRIO_W-1:0]  threshold_n;
  logic [PRIO_W-1:0]  prio_n [NUM_SRC];

  // Bus decode
  logic [3:0]      off_c;
  logic            rd_req_c;
  logic            wr_req_c;
  logic            claim_c;
  logic            complete_c;
  logic [ID_W-1:0] cmp_id_c;

  assign off_c      = bus.plic_addr[5:2];
  assign rd_req_c   = bus.plic_valid && (bus.plic_wstrb == 4'd0);
  assign wr_req_c   = bus.plic_valid && (bus.plic_wstrb != 4'd0);
  assign claim_c    = rd_req_c && (off_c == OFF_CLAIM);
  assign complete_c = wr_req_c && (off_c == OFF_CLAIM);
  assign cmp_id_c   = bus.plic_wdata[ID_W-1:0];

  // Instruction flag and undecoded address/data bits have no effect.
  logic unused_bits;
  assign unused_bits = ^{bus.plic_instr, bus.plic_addr, bus.plic_wdata};

  // Arbitration: highest priority wins, strict '>' keeps the lowest id on ties.
  logic [ID_W-1:0]   best_id_c;
  logic [PRIO_W-1:0] best_prio_c;
  logic              found_c;

  always_comb begin
    best_id_c   = '0;
    best_prio_c = '0;
    found_c     = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && enable[i] && (prio[i] > threshold)) begin
        if (!found_c || (prio[i] > best_prio_c)) begin
          found_c     = 1'b1;
          best_prio_c = prio[i];
          best_id_c   = ID_W'(i + 1);
        end
      end
    end
  end

  // Read data mux; claim returns the current winner.
  logic [DATA_W-1:0] rd_val_c;

  always_comb begin
    rd_val_c = '0;
    case (off_c)
      OFF_PENDING:   rd_val_c = DATA_W'(pending);
      OFF_ENABLE:    rd_val_c = DATA_W'(enable);
      OFF_THRESHOLD: rd_val_c = DATA_W'(threshold);
      OFF_CLAIM:     rd_val_c = DATA_W'(best_id_c);
      default: begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (off_c == 4'(i + OFF_PRIO_BASE)) rd_val_c = DATA_W'(prio[i]);
        end
      end
    endcase
  end

  // Gateway transitions and register writes.
  // In-service sources ignore irq_src; a completed source re-pends one edge later.
  always_comb begin
    pending_n    = pending;
    in_service_n = in_service;
    enable_n     = enable;
    threshold_n  = threshold;
    prio_n       = prio;

    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (in_service[i]) begin
        if (complete_c && (cmp_id_c == ID_W'(i + 1))) in_service_n[i] = 1'b0;
      end else if (pending[i]) begin
        if (claim_c && (best_id_c == ID_W'(i + 1))) begin
          pending_n[i]    = 1'b0;
          in_service_n[i] = 1'b1;
        end
      end else if (irq_src[i]) begin
        pending_n[i] = 1'b1;
      end
    end

    if (wr_req_c) begin
      case (off_c)
        OFF_ENABLE:    enable_n    = bus.plic_wdata[NUM_SRC-1:0];
        OFF_THRESHOLD: threshold_n = bus.plic_wdata[PRIO_W-1:0];
        default: begin
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (off_c == 4'(i + OFF_PRIO_BASE)) prio_n[i] = bus.plic_wdata[PRIO_W-1:0];
          end
        end
      endcase
    end
  end

  // State, bus response and interrupt output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending        <= '0;
      in_service     <= '0;
      enable         <= '0;
      threshold      <= '0;
      prio           <= '{default: '0};
      bus.plic_rdata <= '0;
      bus.plic_ready <= 1'b0;
      ext_irpt       <= 1'b0;
    end else begin
      pending        <= pending_n;
      in_service     <= in_service_n;
      enable         <= enable_n;
      threshold      <= threshold_n;
      prio           <= prio_n;
      bus.plic_ready <= bus.plic_valid;
      ext_irpt       <= (best_id_c != '0);
      if (rd_req_c) bus.plic_rdata <= rd_val_c;
    end
  end

endmodule

// File: tb/tb_plic.sv
// Directed self-checking bench for plic (NUM_SRC=8, PRIO_W=3).
module tb_plic;

  logic       clk;
  logic       rst;
  logic [7:0] irq_src;
  logic       ext_irpt;

  int checks;
  int errors;

  plic_if pif ();

  plic #(.NUM_SRC(8), .PRIO_W(3)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (pif.slave),
    .irq_src  (irq_src),
    .ext_irpt (ext_irpt)
  );

  always #5 clk = ~clk;

  // One bus access: drive at negedge, sample response 1 ns after the next posedge.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic rdy);
    @(negedge clk);
    pif.plic_valid = 1'b1;
    pif.plic_addr  = a;
    pif.plic_wdata = d;
    pif.plic_wstrb = s;
    @(posedge clk);
    #1;
    rd  = pif.plic_rdata;
    rdy = pif.plic_ready;
    pif.plic_valid = 1'b0;
    pif.plic_wstrb = 4'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        rdy;
    bus(a, d, 4'hF, rd, rdy);
  endtask

  // Hold irq_src for one cycle then wait for it to be registered as pending and arbitrated.
  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    irq_src = m;
    @(negedge clk);
    irq_src = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        rdy;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ext_irpt !== 1'b0) begin errors++; $display("FAIL reset_ext got %b want 0", ext_irpt); end
    checks++;
    if (pif.plic_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", pif.plic_ready); end
    for (int o = 0; o < 12; o++) begin
      bus(32'(o * 4), 32'h0, 4'h0, rd, rdy);
      checks++;
      if (rd !== 32'h0 || rdy !== 1'b1) begin
        errors++; $display("FAIL reset_read off=%0d got rdata=%h ready=%b want 0/1", o, rd, rdy);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (pif.plic_ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle got %b want 0", pif.plic_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic        rdy;
    wr(32'h18, 32'd5);
    wr(32'h04, 32'h04);
    wr(32'h08, 32'd0);
    @(negedge clk);
    irq_src = 8'h04;
    @(posedge clk);
    #1;
    checks++;
    if (ext_irpt !== 1'b0) begin errors++; $display("FAIL basic_ext_edge1 got %b want 0", ext_irpt); end
    @(negedge clk);
    irq_src = 8'h00;
    @(posedge clk);
    #1;
    checks++;
    if (ext_irpt !== 1'b1) begin errors++; $display("FAIL basic_ext_edge2 got %b want 1", ext_irpt); end
    bus(32'h00, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'h04) begin errors++; $display("FAIL basic_pending got %h want 04", rd); end
    bus(32'h0C, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd3 || rdy !== 1'b1) begin errors++; $display("FAIL basic_claim got %0d ready=%b want 3/1", rd, rdy); end
    bus(32'h00, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL basic_pending_after_claim got %h want 0", rd); end
    checks++;
    if (ext_irpt !== 1'b0) begin errors++; $display("FAIL basic_ext_fall got %b want 0", ext_irpt); end
    bus(32'h0C, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL basic_second_claim got %0d want 0", rd); end
    wr(32'h0C, 32'd3);
  endtask

  task automatic test_priority_tie();
    logic [31:0] rd;
    logic        rdy;
    wr(32'h14, 32'd3);
    wr(32'h20, 32'd6);
    wr(32'h04, 32'h12);
    pulse(8'h12);
    bus(32'h0C, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd5) begin errors++; $display("FAIL prio_claim got %0d want 5", rd); end
    // 0xE truncates to 6 in a 3-bit field
    wr(32'h14, 32'h0000_000E);
    bus(32'h14, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd6) begin errors++; $display("FAIL prio_truncate got %0d want 6", rd); end
    wr(32'h20, 32'd6);
    wr(32'h0C, 32'd5);
    pulse(8'h10);
    bus(32'h0C, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL tie_claim got %0d want 2", rd); end
    bus(32'h0C, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd5) begin errors++; $display("FAIL tie_claim2 got %0d want 5", rd); end
    wr(32'h0C, 32'd5);
    wr(32'h0C, 32'd2);
  endtask

  task automatic test_threshold();
    logic [31:0] rd;
    logic        rdy;
    wr(32'h08, 32'd6);
    pulse(8'h10);
    @(posedge clk);
    #1;
    checks++;
    if (ext_irpt !== 1'b0) begin errors++; $display("FAIL thr_masked_ext got %b want 0", ext_irpt); end
    bus(32'h0C, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL thr_claim got %0d want 0", rd); end
    bus(32'h00, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'h10) begin errors++; $display("FAIL thr_pending_kept got %h want 10", rd); end
    wr(32'h08, 32'd5);
    @(posedge clk);
    #1;
    checks++;
    if (ext_irpt !== 1'b1) begin errors++; $display("FAIL thr_unmask_ext got %b want 1", ext_irpt); end
    bus(32'h0C, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd5) begin errors++; $display("FAIL thr_unmask_claim got %0d want 5", rd); end
    wr(32'h0C, 32'd5);
    wr(32'h08, 32'd0);
  endtask

  task automatic test_in_service();
    logic [31:0] rd;
    logic        rdy;
    wr(32'h04, 32'h04);
    @(negedge clk);
    irq_src = 8'h04;
    repeat (2) @(posedge clk);
    bus(32'h0C, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd3) begin errors++; $display("FAIL ins_claim got %0d want 3", rd); end
    repeat (2) @(posedge clk);
    bus(32'h00, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL ins_no_repend got %h want 0", rd); end
    wr(32'h0C, 32'd0);
    wr(32'h0C, 32'd9);
    wr(32'h0C, 32'd1);
    @(posedge clk);
    bus(32'h00, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'h0 || ext_irpt !== 1'b0) begin
      errors++; $display("FAIL ins_bad_complete got pending=%h ext=%b want 0/0", rd, ext_irpt);
    end
    wr(32'h0C, 32'd3);
    @(posedge clk);
    bus(32'h00, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'h04) begin errors++; $display("FAIL ins_repend got %h want 04", rd); end
    checks++;
    if (ext_irpt !== 1'b1) begin errors++; $display("FAIL ins_repend_ext got %b want 1", ext_irpt); end
    @(negedge clk);
    irq_src = 8'h00;
    bus(32'h0C, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd3) begin errors++; $display("FAIL ins_reclaim got %0d want 3", rd); end
    wr(32'h0C, 32'd3);
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic        rdy;
    bus(32'h3C, 32'hFFFF_FFFF, 4'hF, rd, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL unmapped_wr_ready got %b want 1", rdy); end
    bus(32'h3C, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'h0 || rdy !== 1'b1) begin errors++; $display("FAIL unmapped_rd got %h ready=%b want 0/1", rd, rdy); end
    bus(32'h04, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'h04) begin errors++; $display("FAIL unmapped_side_effect got %h want 04", rd); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    logic        rdy;
    wr(32'h08, 32'd3);
    pulse(8'h04);
    checks++;
    if (ext_irpt !== 1'b1) begin errors++; $display("FAIL ar_pre_ext got %b want 1", ext_irpt); end
    bus(32'h08, 32'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd3 || rdy !== 1'b1) begin errors++; $display("FAIL ar_pre_read got %0d ready=%b want 3/1", rd, rdy); end
    rst = 1'b1;
    #1;
    checks++;
    if (pif.plic_ready !== 1'b0 || ext_irpt !== 1'b0 || pif.plic_rdata !== 32'h0) begin
      errors++;
      $display("FAIL ar_immediate got ready=%b ext=%b rdata=%h want 0/0/0", pif.plic_ready, ext_irpt, pif.plic_rdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pif.plic_ready !== 1'b0) begin errors++; $display("FAIL ar_ready_after got %b want 0", pif.plic_ready); end
    for (int o = 0; o < 8; o++) begin
      bus(32'(o * 4), 32'h0, 4'h0, rd, rdy);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL ar_cleared off=%0d got %h want 0", o, rd); end
    end
  endtask

  initial begin
    clk            = 1'b0;
    rst            = 1'b1;
    irq_src        = 8'h00;
    pif.plic_valid = 1'b0;
    pif.plic_instr = 1'b0;
    pif.plic_addr  = 32'h0;
    pif.plic_wdata = 32'h0;
    pif.plic_wstrb = 4'h0;
    checks         = 0;
    errors         = 0;
    test_reset();
    test_basic();
    test_priority_tie();
    test_threshold();
    test_in_service();
    test_unmapped();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
